bcd_seq_adder: RTL and testbench
================================

# bcd_seq_adder

Parametrised, digit-serial multi-digit BCD adder. It processes one decimal digit per clock with ripple decimal carry and uses valid/ready handshakes on input and output. It supersedes the single-digit combinational adder for wide decimal operands (counters, display arithmetic) where area matters more than latency.

## Interface
- DIGITS, default 4: number of BCD digits per operand; legal range 1..16.
- clk  in  1: rising-edge clock.
- rst  in  1: synchronous, active-high reset.
- in_valid  in  1: operands present.
- in_ready  out  1: block idle and able to accept operands; equals (state == IDLE).
- a  in  4*DIGITS: operand A, packed BCD, digit 0 in bits [3:0].
- b  in  4*DIGITS: operand B, same packing.
- carry_in  in  1: decimal carry into digit 0. In subtract mode it is the borrow in.
- sub  in  1: present only with BCD_SUB_EN. 1 selects a − b.
- out_valid  out  1: result held and valid.
- out_ready  in  1: consumer accepts the result.
- sum  out  4*DIGITS: BCD result.
- carry  out  1: decimal carry out of the top digit.
- err  out  1: at least one operand digit was greater than 9.

## Operation
- States: IDLE, RUN, DONE.
- IDLE to RUN on in_valid & in_ready.
  - a, b, carry_in (and sub) are registered.
  - Digit index is cleared to 0.
  - err_acc is cleared to 0.
- RUN: each cycle processes digit k.
  - s = a_k + b'_k + c, where s is 5 bits.
  - If s > 9: result digit = (s + 6)[3:0] and c = 1. Otherwise result digit = s[3:0] and c = 0.
  - Result digit k is written into the sum shift register.
  - err_acc is ORed with (a_k > 9) | (b_k > 9).
  - The check uses the raw b_k, before complementing.
- RUN to DONE after digit DIGITS−1 is processed. At that point sum, carry = c and err = err_acc are loaded into the output registers.
- DONE: out_valid = 1. sum, carry and err are held stable until out_ready. On out_valid & out_ready the state goes to IDLE.
- Input handshake rules:
  - Operands are accepted only in IDLE.
  - in_valid during RUN or DONE is ignored; the upstream holds it.
- Invalid digits:
  - The computation still follows the correction rule above.
  - The result is undefined, but err = 1 flags it. No hang or trap occurs.
- Reset (including mid-RUN or in DONE):
  - State returns to IDLE and the operation in progress is discarded.
  - sum = 0, carry = 0, err = 0, out_valid = 0.
  - in_ready = 1 from the first cycle after reset deasserts.

## Timing
- An accept edge E0 gives out_valid = 1 after edge E0 + DIGITS, so latency is DIGITS cycles.
- The earliest next accept is the cycle after the out handshake. Minimum back-to-back period is DIGITS + 2 cycles.
- in_ready is combinational from the state register. The block has no combinational path from in_valid to in_ready, or from out_ready to out_valid.
- Outputs are registered. sum is not updated digit by digit; it changes only on the RUN→DONE edge and at reset.

## Configuration
- BCD_SUB_EN defined:
  - The sub port exists.
  - With sub = 1, b'_k = 9 − b_k and the initial c = ~carry_in. The result is a + (10^DIGITS − 1 − b) + ~borrow_in.
  - carry = 1 means no borrow, and sum = a − b − carry_in.
  - carry = 0 means the result is negative, and sum is its ten's complement.
  - sub = 0 behaves exactly as the non-configured block.
- BCD_SUB_EN undefined: there is no sub port, b'_k = b_k, and the initial c = carry_in.

## Structure
- Shared package bcd_pkg:
  - Digit typedef bcd_digit_t (4 bits).
  - State enum (IDLE/RUN/DONE).
  - Constants BCD_MAX = 9 and BCD_CORR = 6.
- One sub-module, bcd_digit_add:
  - Combinational single-digit adder (a, b, cin → digit, cout, invalid).
  - Optional nine's-complement input when BCD_SUB_EN is defined.
  - It is instantiated once and time-multiplexed across digits.

## Test plan
All scenarios use DIGITS = 4.
- After reset, a = 0000, b = 0000, cin = 0 → sum = 0000, carry = 0, err = 0; out_valid rises 4 cycles after accept.
- a = 0006, b = 0009, cin = 0 → sum = 0015, carry = 0.
- a = 0003, b = 0003, cin = 1 → sum = 0007.
- a = 9999, b = 9999, cin = 1 → sum = 9999, carry = 1.
- a = 000A, b = 0001 → err = 1, with no hang.
- Backpressure: out_ready = 0 for 10 cycles → outputs stay stable and in_ready = 0.
- Reset asserted mid-RUN → out_valid never rises, and a new operation then completes correctly.
- With BCD_SUB_EN:
  - 0100 − 0001, cin = 0 → sum = 0099, carry = 1.
  - 0001 − 0002 → sum = 9999, carry = 0.

Source files
------------

// File: rtl/bcd_pkg.sv
// Shared types and constants for the digit-serial BCD adder.
// Optional subtract support is selected with the BCD_SUB_EN macro.
package bcd_pkg;

    typedef logic [3:0] bcd_digit_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } bcd_state_t;

    localparam bcd_digit_t BCD_MAX  = 4'd9;
    localparam bcd_digit_t BCD_CORR = 4'd6;

endpackage

// File: rtl/bcd_seq_adder_if.sv
// Handshake and operand/result bundle for bcd_seq_adder.
// The sub signal only exists when BCD_SUB_EN is defined.
interface bcd_seq_adder_if #(
    parameter int DIGITS = 4
);
    logic                  in_valid;
    logic                  in_ready;
    logic [4*DIGITS-1:0]   a;
    logic [4*DIGITS-1:0]   b;
    logic                  carry_in;
`ifdef BCD_SUB_EN
    logic                  sub;
`endif
    logic                  out_valid;
    logic                  out_ready;
    logic [4*DIGITS-1:0]   sum;
    logic                  carry;
    logic                  err;

    modport master (
        output in_valid, a, b, carry_in,
`ifdef BCD_SUB_EN
        output sub,
`endif
        output out_ready,
        input  in_ready, out_valid, sum, carry, err
    );

    modport slave (
        input  in_valid, a, b, carry_in,
`ifdef BCD_SUB_EN
        input  sub,
`endif
        input  out_ready,
        output in_ready, out_valid, sum, carry, err
    );
endinterface

// File: rtl/bcd_digit_add.sv
// Combinational single-digit BCD adder with decimal correction.
// With BCD_SUB_EN defined, b can be nine's-complemented for subtraction.
module bcd_digit_add
    import bcd_pkg::*;
(
    input  bcd_digit_t a,
    input  bcd_digit_t b,
    input  logic       cin,
`ifdef BCD_SUB_EN
    input  logic       sub,
`endif
    output bcd_digit_t digit,
    output logic       cout,
    output logic       invalid
);

    logic [4:0] s;
    logic [4:0] corrected;
    bcd_digit_t b_eff;

    // Binary add then fold values above nine back into a decimal digit
    always_comb begin
        b_eff = b;
`ifdef BCD_SUB_EN
        if (sub) b_eff = BCD_MAX - b;
`endif
        invalid   = (a > BCD_MAX) | (b > BCD_MAX);
        s         = {1'b0, a} + {1'b0, b_eff} + {4'b0000, cin};
        corrected = s + {1'b0, BCD_CORR};
        if (s > {1'b0, BCD_MAX}) begin
            digit = corrected[3:0];
            cout  = 1'b1;
        end else begin
            digit = s[3:0];
            cout  = 1'b0;
        end
    end

endmodule

// File: rtl/bcd_seq_adder.sv
// Digit-serial multi-digit BCD adder: one decimal digit per clock, rippling
// the decimal carry through a single time-multiplexed digit adder.
// Defining BCD_SUB_EN adds the sub input (a - b via nine's complement).
module bcd_seq_adder
    import bcd_pkg::*;
#(
    parameter int DIGITS = 4
) (
    input logic           clk,
    input logic           rst,
    bcd_seq_adder_if.slave bus
);

    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IW-1:0] LAST = IW'(DIGITS - 1);

    bcd_state_t          state, state_next;
    logic [4*DIGITS-1:0] a_reg, b_reg;
    logic [4*DIGITS-1:0] sum_work, sum_next;
    logic [4*DIGITS-1:0] sum_q;
    logic [IW-1:0]       idx;
    logic                c_reg;
    logic                err_acc, err_next;
    logic                carry_q, err_q;
`ifdef BCD_SUB_EN
    logic                sub_reg;
`endif

    bcd_digit_t a_dig, b_dig, r_dig;
    logic       d_cout, d_invalid;

    bcd_digit_add u_digit (
        .a       (a_dig),
        .b       (b_dig),
        .cin     (c_reg),
`ifdef BCD_SUB_EN
        .sub     (sub_reg),
`endif
        .digit   (r_dig),
        .cout    (d_cout),
        .invalid (d_invalid)
    );

    // Select the current digit pair and merge the new result digit
    always_comb begin
        a_dig                = a_reg[idx*4 +: 4];
        b_dig                = b_reg[idx*4 +: 4];
        sum_next             = sum_work;
        sum_next[idx*4 +: 4] = r_dig;
        err_next             = err_acc | d_invalid;
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Next-state logic: accept in IDLE, walk all digits, hold until drained
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (bus.in_valid)  state_next = RUN;
            RUN:     if (idx == LAST)   state_next = DONE;
            DONE:    if (bus.out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Handshake outputs decoded purely from the state register
    always_comb begin
        bus.in_ready  = (state == IDLE);
        bus.out_valid = (state == DONE);
    end

    // Operand capture, per-digit accumulation and result loading
    always_ff @(posedge clk) begin
        if (rst) begin
            a_reg    <= '0;
            b_reg    <= '0;
            sum_work <= '0;
            sum_q    <= '0;
            idx      <= '0;
            c_reg    <= 1'b0;
            err_acc  <= 1'b0;
            carry_q  <= 1'b0;
            err_q    <= 1'b0;
`ifdef BCD_SUB_EN
            sub_reg  <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        a_reg   <= bus.a;
                        b_reg   <= bus.b;
                        idx     <= '0;
                        err_acc <= 1'b0;
`ifdef BCD_SUB_EN
                        sub_reg <= bus.sub;
                        c_reg   <= bus.sub ? ~bus.carry_in : bus.carry_in;
`else
                        c_reg   <= bus.carry_in;
`endif
                    end
                end
                RUN: begin
                    sum_work <= sum_next;
                    c_reg    <= d_cout;
                    err_acc  <= err_next;
                    idx      <= idx + 1'b1;
                    if (idx == LAST) begin
                        sum_q   <= sum_next;
                        carry_q <= d_cout;
                        err_q   <= err_next;
                    end
                end
                default: ;
            endcase
        end
    end

    // Registered results drive the bus directly
    always_comb begin
        bus.sum   = sum_q;
        bus.carry = carry_q;
        bus.err   = err_q;
    end

endmodule

// File: tb/tb_bcd_seq_adder.sv
// Directed self-checking bench for bcd_seq_adder with DIGITS = 4.
// Subtract vectors run only when BCD_SUB_EN is defined.
module tb_bcd_seq_adder;

    logic clk;
    logic rst;
    int   compared;
    int   mismatched;
    int   lat;

    bcd_seq_adder_if #(.DIGITS(4)) bus ();

    bcd_seq_adder #(.DIGITS(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Free-running clock, 10 ns period
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check1(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Present operands for one cycle and wait (bounded) for the result
    task automatic applyStimulus(input logic [15:0] av, input logic [15:0] bv,
                                 input logic cin, input logic sb);
        int guard;
        guard = 0;
        @(negedge clk);
        while (bus.in_ready !== 1'b1 && guard < 30) begin
            @(negedge clk);
            guard++;
        end
        bus.a        = av;
        bus.b        = bv;
        bus.carry_in = cin;
`ifdef BCD_SUB_EN
        bus.sub      = sb;
`else
        if (sb) $display("[TB] subtract vector skipped field");
`endif
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        lat = 0;
        while (bus.out_valid !== 1'b1 && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    // Compare result fields and latency, then complete the output handshake
    task automatic checkOutput(input string tag, input logic chk_sum,
                               input logic [15:0] exp_sum, input logic exp_carry,
                               input logic exp_err);
        check1({tag, ".latency"}, 16'(lat), 16'd4);
        if (chk_sum) begin
            check1({tag, ".sum"}, bus.sum, exp_sum);
            check1({tag, ".carry"}, {15'd0, bus.carry}, {15'd0, exp_carry});
        end
        check1({tag, ".err"}, {15'd0, bus.err}, {15'd0, exp_err});
        @(negedge clk);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        check1({tag, ".in_ready_after"}, {15'd0, bus.in_ready}, 16'd1);
    endtask

    // Directed sequence
    initial begin
        compared      = 0;
        mismatched    = 0;
        lat           = 0;
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.carry_in  = 1'b0;
        bus.out_ready = 1'b0;
`ifdef BCD_SUB_EN
        bus.sub       = 1'b0;
`endif
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check1("reset.in_ready", {15'd0, bus.in_ready}, 16'd1);
        check1("reset.out_valid", {15'd0, bus.out_valid}, 16'd0);
        check1("reset.sum", bus.sum, 16'h0000);
        check1("reset.carry", {15'd0, bus.carry}, 16'd0);
        check1("reset.err", {15'd0, bus.err}, 16'd0);

        applyStimulus(16'h0000, 16'h0000, 1'b0, 1'b0);
        checkOutput("zero", 1'b1, 16'h0000, 1'b0, 1'b0);

        applyStimulus(16'h0006, 16'h0009, 1'b0, 1'b0);
        checkOutput("6p9", 1'b1, 16'h0015, 1'b0, 1'b0);

        applyStimulus(16'h0003, 16'h0003, 1'b1, 1'b0);
        checkOutput("3p3c", 1'b1, 16'h0007, 1'b0, 1'b0);

        applyStimulus(16'h9999, 16'h9999, 1'b1, 1'b0);
        checkOutput("all9", 1'b1, 16'h9999, 1'b1, 1'b0);

        applyStimulus(16'h1234, 16'h5678, 1'b0, 1'b0);
        checkOutput("mixed", 1'b1, 16'h6912, 1'b0, 1'b0);

        applyStimulus(16'h5000, 16'h5000, 1'b0, 1'b0);
        checkOutput("topcarry", 1'b1, 16'h0000, 1'b1, 1'b0);

        applyStimulus(16'h000A, 16'h0001, 1'b0, 1'b0);
        checkOutput("baddigit", 1'b0, 16'h0000, 1'b0, 1'b1);

        applyStimulus(16'h0042, 16'h0058, 1'b0, 1'b0);
        check1("bp.sum0", bus.sum, 16'h0100);
        bus.in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check1("bp.sum", bus.sum, 16'h0100);
            check1("bp.out_valid", {15'd0, bus.out_valid}, 16'd1);
            check1("bp.in_ready", {15'd0, bus.in_ready}, 16'd0);
        end
        bus.in_valid = 1'b0;
        checkOutput("bp", 1'b1, 16'h0100, 1'b0, 1'b0);

        @(negedge clk);
        bus.a        = 16'h0011;
        bus.b        = 16'h0022;
        bus.carry_in = 1'b0;
        bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check1("midrst.in_ready", {15'd0, bus.in_ready}, 16'd1);
        check1("midrst.sum", bus.sum, 16'h0000);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check1("midrst.out_valid", {15'd0, bus.out_valid}, 16'd0);
        end
        applyStimulus(16'h0123, 16'h0456, 1'b0, 1'b0);
        checkOutput("afterrst", 1'b1, 16'h0579, 1'b0, 1'b0);

`ifdef BCD_SUB_EN
        applyStimulus(16'h0100, 16'h0001, 1'b0, 1'b1);
        checkOutput("sub100m1", 1'b1, 16'h0099, 1'b1, 1'b0);

        applyStimulus(16'h0001, 16'h0002, 1'b0, 1'b1);
        checkOutput("sub1m2", 1'b1, 16'h9999, 1'b0, 1'b0);

        applyStimulus(16'h0006, 16'h0009, 1'b0, 1'b0);
        checkOutput("subdis", 1'b1, 16'h0015, 1'b0, 1'b0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
